// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the run-time clock divider controller.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIV   = 1;

endpackage

// File: rtl/clk_div_core.sv
// Divide-by-n engine: half-period counter, toggle flop and divisor register with a load port.
module clk_div_core #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_div,
  output logic             div_clk,
  output logic             div_tick,
  output logic             fall,
  output logic [WIDTH-1:0] cur_div
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // The divisor is never zero, so div_q-1 cannot underflow.
  assign wrap = en && (count_q == div_q - WIDTH'(1));
  assign fall = wrap && clk_q;

  always_comb begin
    count_d = count_q;
    clk_d   = clk_q;
    div_d   = div_q;
    tick_d  = wrap;
    if (wrap) begin
      count_d = '0;
      clk_d   = ~clk_q;
    end else if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
    if (load) begin
      div_d   = load_div;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      div_q   <= WIDTH'(DEFAULT_DIV);
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign div_clk  = clk_q;
  assign div_tick = tick_q;
  assign cur_div  = div_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divisor controller: round-robin update arbitration, one pending slot, glitch-free start/stop.
// Optional statistics outputs are enabled with `define CLK_DIV_CTRL_STATS_EN.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_REQ     = 2,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_div,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     req_err,
  output logic                     div_clk,
  output logic                     div_tick,
  output logic [WIDTH-1:0]         cur_div,
  output logic                     busy
`ifdef CLK_DIV_CTRL_STATS_EN
  ,
  output logic [15:0]              period_cnt,
  output logic                     err_sticky
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic               gnt_any;
  logic [WIDTH-1:0]   gnt_div;
  logic [PW-1:0]      gnt_next;
  int                 idx;

  logic core_en, core_clr, apply, fall;

  clk_div_core #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .en      (core_en),
    .clr     (core_clr),
    .load    (apply),
    .load_div(pdiv_q),
    .div_clk (div_clk),
    .div_tick(div_tick),
    .fall    (fall),
    .cur_div (cur_div)
  );

  // Round-robin search starting at the pointer; only offered while the slot is empty.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_div  = '0;
    gnt_next = '0;
    idx      = 0;
    if (!pend_q && !rst) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any    = 1'b1;
          grant[idx] = 1'b1;
          gnt_div    = req_div[idx*WIDTH +: WIDTH];
          gnt_next   = (idx == NUM_REQ - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  always_comb begin
    core_en  = (state_q == RUN && (run || div_clk)) || state_q == STOPPING;
    core_clr = (state_q == RUN) && !run && !div_clk;
    apply    = pend_q && (state_q == IDLE || fall);
    state_d  = state_q;
    pend_d   = pend_q;
    pdiv_d   = pdiv_q;
    ptr_d    = ptr_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE:     if (run) state_d = RUN;
      RUN: begin
        if (!run) state_d = (div_clk && !fall) ? STOPPING : IDLE;
      end
      STOPPING: begin
        if (run)       state_d = RUN;
        else if (fall) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
    if (apply) pend_d = 1'b0;
    // A zero divisor completes its handshake but is discarded and flagged.
    if (gnt_any) begin
      ptr_d = gnt_next;
      if (gnt_div == '0) begin
        err_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        pdiv_d = gnt_div;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      pdiv_q  <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pdiv_q  <= pdiv_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = grant;
  assign req_err   = err_q;
  assign busy      = pend_q || (state_q == STOPPING);

`ifdef CLK_DIV_CTRL_STATS_EN
  logic [15:0] period_q;
  logic        sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      period_q <= period_q + (fall ? 16'd1 : 16'd0);
      sticky_q <= sticky_q | err_q;
    end
  end

  assign period_cnt = period_q;
  assign err_sticky = sticky_q;
`endif

endmodule
